mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-master, one-slave bus arbiter. It shares a single memory port between the CPU instruction bus (Iw*) and data bus (Dw*). It is used when the CPU core's separate instruction and data buses must be served by one unified memory or bus slave. Data accesses have priority, with a starvation guard for instruction fetch and a timeout that converts a missing slave acknowledge into a bus error.

## Interface
Parameters:
- TIMEOUT, 16: cycles in a GRANT state without iMemAck before the transaction is aborted (2..255).
- STARVE_LIMIT, 4: consecutive D grants with a pending I request before I is forced (1..15).

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset; asynchronous, active-low.
- iIwReadEnable, iIwWriteEnable  in  1  instruction master request (read or write).
- iIwByteEnable  in  4  instruction master byte lanes.
- iIwAddress, iIwWriteData  in  32  instruction master address and write data.
- oIwReadData  out  32  instruction read data; valid while oIwReady=1.
- oIwReady  out  1  instruction transaction complete, one-cycle pulse.
- iDwReadEnable, iDwWriteEnable, iDwByteEnable, iDwAddress, iDwWriteData  in  1/1/4/32/32  data master, same meaning as the I set.
- oDwReadData  out  32  data read data; oDwReady  out  1  data completion pulse.
- oMemReq  out  1  slave request; oMemWrite  out  1  1=write.
- oMemByteEnable  out  4; oMemAddress, oMemWriteData  out  32  latched transaction fields.
- iMemReadData  in  32; iMemAck  in  1  slave completion (any latency ≥0 cycles after oMemReq rises).
- oBusError  out  1  one-cycle pulse on timeout abort.
- oGrant  out  2  monitor: 00 none, 01 I, 10 D.

## Operation
- A master requests by holding ReadEnable or WriteEnable high with stable fields until its Ready pulse. If both ReadEnable and WriteEnable are high, the request is a write.
- States are IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
- IDLE → GRANT_D if D requests and (I does not request or starve_cnt < STARVE_LIMIT).
- IDLE → GRANT_I if I requests and (D does not request or starve_cnt ≥ STARVE_LIMIT).
- IDLE with no request stays in IDLE.
- On entering a GRANT state, the winner's address, write data, byte enable and write flag are latched into the oMem* registers. oMemReq=1 for the whole GRANT state.
- GRANT_x with iMemAck=1 → RESP_x. iMemReadData is registered into oXReadData (writes register it too; the value is don't-care to the master). oXReady=1 in RESP_x.
- GRANT_x with the wait counter reaching TIMEOUT-1 and iMemAck=0 → RESP_x with oXReadData=0 and oBusError=1 in RESP_x.
- If iMemAck and the timeout coincide, the ack wins and no error is raised.
- RESP_x → IDLE unconditionally. RESP is the turnaround cycle in which the master drops or changes its request. Requests are not sampled in RESP.
- starve_cnt (4 bits):
  - On a GRANT_D entry with I requesting, increment, saturating at STARVE_LIMIT.
  - On a GRANT_D entry with I idle, clear to 0.
  - On a GRANT_I entry, clear to 0.
- The wait counter (8 bits) clears on GRANT entry and increments each GRANT cycle.
- iMemAck outside GRANT states is ignored.
- A master dropping its request mid-GRANT does not cancel the transaction. The slave still completes it, and the Ready pulse is issued anyway.
- Unselected master Ready outputs stay 0. Unselected ReadData holds its last value.

## Timing
- Reset (iRST=0, async): state IDLE. oMemReq, oMemWrite, oIwReady, oDwReady and oBusError are 0. oMemByteEnable=0, oMemAddress=0, oMemWriteData=0, oIwReadData=0, oDwReadData=0, oGrant=00, both counters 0.
- Reset asserted mid-transaction aborts it immediately, with no Ready and no error pulse. Release is synchronous to the next edge, and the first arbitration happens on the first edge after release.
- All outputs are registered; there is no combinational input-to-output path.
- Request seen in IDLE at edge N: GRANT from N+1, so oMemReq is high in cycle N+1.
- Ack sampled at edge M: RESP (Ready high) in cycle M+1, IDLE in M+2, next grant earliest M+3.
- A zero-wait slave gives 3 cycles per transaction and a throughput of 1 access per 3 cycles.
- With timeout and no ack: oMemReq is high for exactly TIMEOUT cycles, then there is one RESP cycle with oBusError=1.

## Test plan
- Single D read, slave acks in the first GRANT cycle, iMemReadData=0xDEADBEEF → oMemReq high 1 cycle with oMemAddress=D address. oDwReady pulses 1 cycle later with oDwReadData=0xDEADBEEF. oIwReady stays 0.
- I and D request continuously, zero-wait slave, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I; oGrant matches each grant.
- D write (iDwByteEnable=4'b0011, data 0x12345678), slave acks after 5 cycles → oMemWrite=1 and the fields stay stable for 6 GRANT cycles. oDwReady pulses once; no bus error.
- I read with slave never acking, TIMEOUT=16 → oMemReq high 16 cycles, then oIwReady=1, oBusError=1 and oIwReadData=0 in the same cycle, then IDLE.
- Ack arrives in the 16th GRANT cycle (coincides with timeout) → normal completion, oBusError stays 0.
- iRST pulled low during the 3rd GRANT cycle → every output is 0 within the same cycle. After release, the held D request is re-granted on the first edge with starve_cnt=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares one memory/slave port between a CPU instruction master (Iw*) and a
//   data master (Dw*). Data accesses win arbitration. A starvation counter
//   forces an instruction grant after STARVE_LIMIT back-to-back data grants
//   while an instruction request is pending. A wait counter aborts any grant
//   that sees no slave acknowledge within TIMEOUT cycles and reports it as a
//   one-cycle bus error.
//
//   Every transaction takes the path IDLE -> GRANT_x -> RESP_x -> IDLE. The
//   RESP cycle is a turnaround cycle: the master sees its Ready pulse and
//   may drop or change its request, so requests are not sampled there.
//
// Parameters:
//   TIMEOUT       cycles spent in GRANT without iMemAck before abort (2..255)
//   STARVE_LIMIT  D grants with I pending before I is forced       (1..15)
//
// Ports:
//   iCLK, iRST                  clock (rising edge); async active-low reset
//   iIw*/iDw* ReadEnable,
//     WriteEnable, ByteEnable,
//     Address, WriteData        master requests (write wins if both enables)
//   oIwReadData/oDwReadData     registered read data (0 after a timeout)
//   oIwReady/oDwReady           one-cycle completion pulse (RESP state)
//   oMemReq                     high for the whole GRANT state
//   oMemWrite, oMemByteEnable,
//     oMemAddress,
//     oMemWriteData             fields latched from the winner on grant
//   iMemReadData, iMemAck       slave response
//   oBusError                   one-cycle pulse in RESP after a timeout
//   oGrant                      monitor: 00 none, 01 I, 10 D (GRANT state)
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        iCLK,
    input  logic        iRST,

    input  logic        iIwReadEnable,
    input  logic        iIwWriteEnable,
    input  logic [3:0]  iIwByteEnable,
    input  logic [31:0] iIwAddress,
    input  logic [31:0] iIwWriteData,
    output logic [31:0] oIwReadData,
    output logic        oIwReady,

    input  logic        iDwReadEnable,
    input  logic        iDwWriteEnable,
    input  logic [3:0]  iDwByteEnable,
    input  logic [31:0] iDwAddress,
    input  logic [31:0] iDwWriteData,
    output logic [31:0] oDwReadData,
    output logic        oDwReady,

    output logic        oMemReq,
    output logic        oMemWrite,
    output logic [3:0]  oMemByteEnable,
    output logic [31:0] oMemAddress,
    output logic [31:0] oMemWriteData,
    input  logic [31:0] iMemReadData,
    input  logic        iMemAck,

    output logic        oBusError,
    output logic [1:0]  oGrant
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT_I = 3'd1,
        S_GRANT_D = 3'd2,
        S_RESP_I  = 3'd3,
        S_RESP_D  = 3'd4
    } state_t;

    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] LP_STARVE    = 4'(STARVE_LIMIT);

    localparam logic [1:0] LP_GNT_NONE = 2'b00;
    localparam logic [1:0] LP_GNT_I    = 2'b01;
    localparam logic [1:0] LP_GNT_D    = 2'b10;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_starve_cnt;
    logic [7:0]  r_wait_cnt;

    logic        r_mem_req;
    logic        r_mem_write;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [31:0] r_iw_rdata;
    logic [31:0] r_dw_rdata;
    logic        r_iw_ready;
    logic        r_dw_ready;
    logic        r_bus_error;
    logic [1:0]  r_grant;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t      w_state_next;
    logic [3:0]  w_starve_next;
    logic [7:0]  w_wait_next;

    logic        w_mem_req_next;
    logic        w_mem_write_next;
    logic [3:0]  w_mem_be_next;
    logic [31:0] w_mem_addr_next;
    logic [31:0] w_mem_wdata_next;

    logic [31:0] w_iw_rdata_next;
    logic [31:0] w_dw_rdata_next;
    logic        w_iw_ready_next;
    logic        w_dw_ready_next;
    logic        w_bus_error_next;
    logic [1:0]  w_grant_next;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic        w_i_req;
    logic        w_d_req;
    logic        w_starve_below;
    logic        w_pick_d;
    logic        w_pick_i;
    logic        w_in_grant;
    logic        w_grant_is_d;
    logic        w_timeout_hit;
    logic [3:0]  w_starve_inc;

    assign w_i_req        = iIwReadEnable | iIwWriteEnable;
    assign w_d_req        = iDwReadEnable | iDwWriteEnable;
    assign w_starve_below = (r_starve_cnt < LP_STARVE);

    // D wins unless I has been passed over STARVE_LIMIT times in a row.
    assign w_pick_d = w_d_req & (~w_i_req | w_starve_below);
    assign w_pick_i = w_i_req & (~w_d_req | ~w_starve_below);

    assign w_in_grant    = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);
    assign w_grant_is_d  = (r_state == S_GRANT_D);
    assign w_timeout_hit = (r_wait_cnt == LP_WAIT_LAST);

    // Saturating increment; the IDLE decision already keeps it at or below
    // the limit, the clamp just makes that explicit.
    assign w_starve_inc = (r_starve_cnt >= LP_STARVE) ? LP_STARVE
                                                      : r_starve_cnt + 4'd1;

    // -------------------------------------------------------------------------
    // State register and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_wait_cnt   <= 8'd0;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_be     <= 4'd0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_iw_rdata   <= 32'd0;
            r_dw_rdata   <= 32'd0;
            r_iw_ready   <= 1'b0;
            r_dw_ready   <= 1'b0;
            r_bus_error  <= 1'b0;
            r_grant      <= LP_GNT_NONE;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_wait_cnt   <= w_wait_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_write  <= w_mem_write_next;
            r_mem_be     <= w_mem_be_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_iw_rdata   <= w_iw_rdata_next;
            r_dw_rdata   <= w_dw_rdata_next;
            r_iw_ready   <= w_iw_ready_next;
            r_dw_ready   <= w_dw_ready_next;
            r_bus_error  <= w_bus_error_next;
            r_grant      <= w_grant_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Defaults: hold state, counters, latched fields and read data;
        // pulse outputs low; no request.
        w_state_next     = r_state;
        w_starve_next    = r_starve_cnt;
        w_wait_next      = r_wait_cnt;
        w_mem_req_next   = 1'b0;
        w_mem_write_next = r_mem_write;
        w_mem_be_next    = r_mem_be;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_iw_rdata_next  = r_iw_rdata;
        w_dw_rdata_next  = r_dw_rdata;
        w_iw_ready_next  = 1'b0;
        w_dw_ready_next  = 1'b0;
        w_bus_error_next = 1'b0;
        w_grant_next     = LP_GNT_NONE;

        case (r_state)
            S_IDLE: begin
                if (w_pick_d) begin
                    w_state_next     = S_GRANT_D;
                    w_mem_req_next   = 1'b1;
                    w_grant_next     = LP_GNT_D;
                    w_wait_next      = 8'd0;
                    w_mem_write_next = iDwWriteEnable;
                    w_mem_be_next    = iDwByteEnable;
                    w_mem_addr_next  = iDwAddress;
                    w_mem_wdata_next = iDwWriteData;
                    // Count only grants that actually passed I over.
                    w_starve_next    = w_i_req ? w_starve_inc : 4'd0;
                end else if (w_pick_i) begin
                    w_state_next     = S_GRANT_I;
                    w_mem_req_next   = 1'b1;
                    w_grant_next     = LP_GNT_I;
                    w_wait_next      = 8'd0;
                    w_mem_write_next = iIwWriteEnable;
                    w_mem_be_next    = iIwByteEnable;
                    w_mem_addr_next  = iIwAddress;
                    w_mem_wdata_next = iIwWriteData;
                    w_starve_next    = 4'd0;
                end
            end

            S_GRANT_I, S_GRANT_D: begin
                if (iMemAck) begin
                    // Ack has priority over a coincident timeout.
                    w_state_next = w_grant_is_d ? S_RESP_D : S_RESP_I;
                    if (w_grant_is_d) begin
                        w_dw_rdata_next = iMemReadData;
                        w_dw_ready_next = 1'b1;
                    end else begin
                        w_iw_rdata_next = iMemReadData;
                        w_iw_ready_next = 1'b1;
                    end
                end else if (w_timeout_hit) begin
                    w_state_next     = w_grant_is_d ? S_RESP_D : S_RESP_I;
                    w_bus_error_next = 1'b1;
                    if (w_grant_is_d) begin
                        w_dw_rdata_next = 32'd0;
                        w_dw_ready_next = 1'b1;
                    end else begin
                        w_iw_rdata_next = 32'd0;
                        w_iw_ready_next = 1'b1;
                    end
                end else begin
                    w_mem_req_next = 1'b1;
                    w_grant_next   = w_grant_is_d ? LP_GNT_D : LP_GNT_I;
                    w_wait_next    = r_wait_cnt + 8'd1;
                end
            end

            S_RESP_I, S_RESP_D: begin
                // Turnaround: requests are deliberately ignored here.
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign oMemReq        = r_mem_req;
    assign oMemWrite      = r_mem_write;
    assign oMemByteEnable = r_mem_be;
    assign oMemAddress    = r_mem_addr;
    assign oMemWriteData  = r_mem_wdata;
    assign oIwReadData    = r_iw_rdata;
    assign oDwReadData    = r_dw_rdata;
    assign oIwReady       = r_iw_ready;
    assign oDwReady       = r_dw_ready;
    assign oBusError      = r_bus_error;
    assign oGrant         = r_grant;

    // w_in_grant documents the grant states; keep it referenced so the
    // decode stays readable without tripping unused-signal checks.
    logic w_unused;
    assign w_unused = w_in_grant;

endmodule
